// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, alu_op
// names ({funct3, instr[30]}), FSM state and error code enums.
package instr_encoder_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } enc_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_RANGE    = 2'b11
  } enc_err_t;

  // Shift ops carry shamt in the immediate field and keep bit30 as funct7[5]
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor -> RV32I word mapper.
// Optional immediate range check enabled by ENC_IMM_RANGE_CHECK_EN;
// without it immediates are silently truncated and range_err stays 0.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic        is_imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [3:0]  alu_op,
  input  logic [31:0] imm,
  output logic [31:0] wdata,
  output logic        illegal,
  output logic        range_err
);

  logic [2:0] funct3;
  logic       bit30;
  logic       shift_op;
  logic       unused_imm_hi;

  assign funct3        = alu_op[3:1];
  assign bit30         = alu_op[0];
  assign shift_op      = is_shift(funct3);
  // Upper immediate bits only matter to the optional range check
  assign unused_imm_hi = ^imm[31:12];

  // Select the instruction format and flag SUBI-style encodings
  always_comb begin
    wdata   = '0;
    illegal = 1'b0;
    if (!is_imm) begin
      wdata = {1'b0, bit30, 5'b00000, rs2, rs1, funct3, rd, R_TYPE};
    end else if (shift_op) begin
      wdata = {1'b0, bit30, 5'b00000, imm[4:0], rs1, funct3, rd, I_TYPE};
    end else begin
      wdata   = {imm[11:0], rs1, funct3, rd, I_TYPE};
      illegal = bit30;
    end
  end

`ifdef ENC_IMM_RANGE_CHECK_EN
  // Immediate must fit its field: signed 12-bit, or shamt 0..31
  always_comb begin
    range_err = 1'b0;
    if (is_imm) begin
      if (shift_op) begin
        range_err = (imm > 32'd31);
      end else begin
        range_err = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
      end
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams instruction descriptors into imem as RV32I words.
// FSM IDLE/RUN/DONE/ERR, word counter and registered imem write port.
// Optional macro ENC_IMM_RANGE_CHECK_EN enables immediate range errors.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic                       s_is_imm,
  input  logic [4:0]                 s_rd,
  input  logic [4:0]                 s_rs1,
  input  logic [4:0]                 s_rs2,
  input  logic [3:0]                 s_alu_op,
  input  logic [31:0]                s_imm,
  output logic                       imem_we,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  enc_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  enc_err_t      err_code_q, err_code_d;

  logic [31:0]   pk_wdata;
  logic          pk_illegal;
  logic          pk_range_err;
  logic          accept;

  instr_pack u_pack (
    .is_imm    (s_is_imm),
    .rd        (s_rd),
    .rs1       (s_rs1),
    .rs2       (s_rs2),
    .alu_op    (s_alu_op),
    .imm       (s_imm),
    .wdata     (pk_wdata),
    .illegal   (pk_illegal),
    .range_err (pk_range_err)
  );

  assign s_ready = (state_q == ST_RUN) && (count_q < DEPTH_C);
  assign accept  = s_valid && s_ready;

  // Next-state, counter and write-port logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d    = ST_RUN;
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (pk_illegal) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (pk_range_err) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            wdata_d = pk_wdata;
            count_d = count_q + CW'(1);
            if (s_last) begin
              state_d = ST_DONE;
            end
          end
        end else if (s_valid && (count_q == DEPTH_C)) begin
          // Image is full but the host keeps sending: nothing is written
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_OVERFLOW;
        end
      end
      ST_DONE: begin
        // done pulses once the final word has been presented on the port
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset kills any pending write at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4, BASE near the top of the
// address space so the 32-bit address wrap is exercised).
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        s_is_imm;
  logic [4:0]  s_rd;
  logic [4:0]  s_rs1;
  logic [4:0]  s_rs2;
  logic [3:0]  s_alu_op;
  logic [31:0] s_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_is_imm(s_is_imm), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_alu_op(s_alu_op), .s_imm(s_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic        is_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  op;
    logic [31:0] imm;
  } desc_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   wr_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented write is popped against the scoreboard
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", imem_addr, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", imem_addr, e.addr);
          chk("wr_data", imem_wdata, e.data);
          $display("write addr=%h data=%h", imem_addr, imem_wdata);
        end
      end
    end
  end

  // Reference: field arithmetic straight from the RV32I formats.
  // kind 0 = written, 1 = illegal, 3 = immediate out of range
  function automatic void ref_encode(input desc_t d, output int kind, output logic [31:0] word);
    int f3, b30, immv, rd, rs1, rs2, fld;
    bit sh;
    longint w;
    f3   = int'(d.op) / 2;
    b30  = int'(d.op) % 2;
    rd   = int'(d.rd);
    rs1  = int'(d.rs1);
    rs2  = int'(d.rs2);
    immv = $signed(d.imm);
    sh   = (f3 == 1) || (f3 == 5);
    kind = 0;
    if (!d.is_imm) begin
      w = longint'(b30) * 1073741824 + longint'(rs2) * 1048576 + rs1 * 32768
          + f3 * 4096 + rd * 128 + 51;
    end else if (!sh) begin
      fld = ((immv % 4096) + 4096) % 4096;
      w = longint'(fld) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
      if (b30 == 1) kind = 1;
`ifdef ENC_IMM_RANGE_CHECK_EN
      else if (immv < -2048 || immv > 2047) kind = 3;
`endif
    end else begin
      fld = ((immv % 32) + 32) % 32;
      w = longint'(b30) * 1073741824 + longint'(fld) * 1048576 + rs1 * 32768
          + f3 * 4096 + rd * 128 + 19;
`ifdef ENC_IMM_RANGE_CHECK_EN
      if (immv < 0 || immv > 31) kind = 3;
`endif
    end
    word = w[31:0];
  endfunction

  function automatic desc_t mk(input logic is_imm, input int rd, input int rs1, input int rs2,
                               input logic [3:0] op, input int imm);
    desc_t d;
    d.is_imm = is_imm;
    d.rd     = 5'(rd);
    d.rs1    = 5'(rs1);
    d.rs2    = 5'(rs2);
    d.op     = op;
    d.imm    = 32'(imm);
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.is_imm = 1'($urandom_range(1));
    d.rd     = 5'($urandom);
    d.rs1    = 5'($urandom);
    d.rs2    = 5'($urandom);
    d.op     = 4'($urandom);
    case ($urandom_range(3))
      0:       d.imm = 32'($urandom_range(31));
      1:       d.imm = 32'($urandom_range(4095)) - 32'd2048;
      default: d.imm = $urandom;
    endcase
    return d;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_idx = 0;
  endtask

  // Hold the beat until the DUT takes it; returns at #1 after the accept edge
  task automatic drive_beat(input desc_t d, input logic last);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_last = last;
    s_is_imm = d.is_imm; s_rd = d.rd; s_rs1 = d.rs1; s_rs2 = d.rs2;
    s_alu_op = d.op; s_imm = d.imm;
    for (int i = 0; i < 40; i++) begin
      if (s_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Model-driven beat: push the expected write, return the expected outcome
  task automatic send(input desc_t d, input logic last, output int kind);
    logic [31:0] word;
    ref_encode(d, kind, word);
    if (kind == 0) begin
      exp_q.push_back({BASE + 32'(4 * m_idx), word});
      m_idx++;
    end
    drive_beat(d, last);
  endtask

  task automatic send_fixed(input desc_t d, input logic last, input logic [31:0] word);
    exp_q.push_back({BASE + 32'(4 * m_idx), word});
    m_idx++;
    drive_beat(d, last);
  endtask

  task automatic expect_err(input logic [1:0] code);
    chk("err", {31'd0, err}, 32'd1);
    chk("err_code", {30'd0, err_code}, {30'd0, code});
    chk("ready_in_err", {31'd0, s_ready}, 32'd0);
    chk("busy_in_err", {31'd0, busy}, 32'd0);
  endtask

  // Called right after the last accept: done must pulse on the following cycle
  task automatic expect_done(input int n);
    chk("done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("done", {31'd0, done}, 32'd1);
    chk("count_done", {29'd0, count}, 32'(n));
    @(posedge clk); #1;
    chk("done_width", {31'd0, done}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    desc_t d;
    int    kind, n;
    logic  stop;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_is_imm = 1'b0; s_rd = '0; s_rs1 = '0; s_rs2 = '0; s_alu_op = '0; s_imm = '0;
    #12;
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_flags", {27'd0, busy, done, err, err_code}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single R ADD
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_fixed(mk(1'b0, 3, 1, 2, 4'b0000, 0), 1'b1, 32'h002081B3);
    expect_done(1);
    drain();

    // R SUB then I ADD back-to-back
    wr_cyc_q.delete();
    pulse_start();
    send_fixed(mk(1'b0, 5, 6, 7, 4'b0001, 0), 1'b0, 32'h407302B3);
    send_fixed(mk(1'b1, 1, 0, 0, 4'b0000, -1), 1'b1, 32'hFFF00093);
    expect_done(2);
    drain();
    if (wr_cyc_q.size() == 2) chk("b2b_gap", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);
    else chk("b2b_writes", 32'(wr_cyc_q.size()), 32'd2);

    // I SRA
    pulse_start();
    send_fixed(mk(1'b1, 2, 2, 0, 4'b1011, 3), 1'b1, 32'h40315113);
    expect_done(1);
    drain();

    // Illegal SUBI, then restart from ERR
    pulse_start();
    drive_beat(mk(1'b1, 4, 4, 0, 4'b0001, 5), 1'b1);
    expect_err(2'b01);
    pulse_start();
    chk("restart_err", {31'd0, err}, 32'd0);
    chk("restart_code", {30'd0, err_code}, 32'd0);
    chk("restart_count", {29'd0, count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);

    // Fill all DEPTH words, then one more beat overflows (addresses wrap)
    for (int i = 0; i < DEPTH; i++) begin
      d = mk(1'b0, i + 1, i + 2, i + 3, 4'b0000, 0);
      send(d, 1'b0, kind);
    end
    chk("count_full", {29'd0, count}, 32'(DEPTH));
    s_valid = 1'b1;
    chk("ready_full", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    expect_err(2'b10);
    drain();

    // Random programs against the reference model
    for (int p = 0; p < 12; p++) begin
      pulse_start();
      n = $urandom_range(1, DEPTH);
      stop = 1'b0;
      for (int b = 0; b < n && !stop; b++) begin
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
        d = rand_desc();
        send(d, (b == n - 1), kind);
        if (kind != 0) begin
          expect_err(2'(kind));
          stop = 1'b1;
        end else if (b == n - 1) begin
          expect_done(n);
        end
      end
      drain();
    end

    // Asynchronous reset while a write is pending: it must never appear
    pulse_start();
    drive_beat(mk(1'b0, 9, 9, 9, 4'b0000, 0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, imem_we}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_wdata", imem_wdata, 32'd0);
    chk("arst_flags", {24'd0, s_ready, count, busy, done, err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Immediate one past the signed 12-bit range
    pulse_start();
    send(mk(1'b1, 1, 1, 0, 4'b0000, 2048), 1'b1, kind);
    if (kind == 3) expect_err(2'b11);
    else expect_done(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<200000", $time);
    $fatal(1);
  end

endmodule
